// File: rtl/ialu_req_pkg.sv
// ialu_req_pkg: IALU command encodings, widths and request FSM states shared by the EXU request controller.
package ialu_req_pkg;
   localparam int SCR1_XLEN             = 32;
   localparam int SCR1_IALU_CMD_WIDTH_E = 5;

   typedef enum logic [SCR1_IALU_CMD_WIDTH_E-1:0] {
      SCR1_IALU_CMD_NONE,
      SCR1_IALU_CMD_AND,
      SCR1_IALU_CMD_OR,
      SCR1_IALU_CMD_XOR,
      SCR1_IALU_CMD_ADD,
      SCR1_IALU_CMD_SUB,
      SCR1_IALU_CMD_SUB_LT,
      SCR1_IALU_CMD_SUB_LTU,
      SCR1_IALU_CMD_SUB_EQ,
      SCR1_IALU_CMD_SUB_NE,
      SCR1_IALU_CMD_SUB_GE,
      SCR1_IALU_CMD_SUB_GEU,
      SCR1_IALU_CMD_SLL,
      SCR1_IALU_CMD_SRL,
      SCR1_IALU_CMD_SRA,
      SCR1_IALU_CMD_MUL,
      SCR1_IALU_CMD_MULHU,
      SCR1_IALU_CMD_MULHSU,
      SCR1_IALU_CMD_MULH,
      SCR1_IALU_CMD_DIV,
      SCR1_IALU_CMD_DIVU,
      SCR1_IALU_CMD_REM,
      SCR1_IALU_CMD_REMU
   } type_scr1_ialu_cmd_sel_e;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RVM_WAIT, ST_RESP} ialu_req_state_e;

   function automatic logic ialu_cmd_is_rvm(input logic [SCR1_IALU_CMD_WIDTH_E-1:0] cmd);
      return cmd >= SCR1_IALU_CMD_MUL && cmd <= SCR1_IALU_CMD_REMU;
   endfunction
endpackage

// File: rtl/ialu_exu_req_ctrl.sv
// ialu_exu_req_ctrl: single-outstanding EXU request initiator for the IALU, with MUL/DIV wait and timeout.
module ialu_exu_req_ctrl
   import ialu_req_pkg::*;
#(
   parameter int XLEN    = SCR1_XLEN,
   parameter int CMD_W   = SCR1_IALU_CMD_WIDTH_E,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_vld_i,
   output logic             req_rdy_o,
   input  logic [CMD_W-1:0] req_cmd_i,
   input  logic [XLEN-1:0]  req_op1_i,
   input  logic [XLEN-1:0]  req_op2_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output logic [CMD_W-1:0] exu2ialu_cmd_o,
   output logic [XLEN-1:0]  exu2ialu_main_op1_o,
   output logic [XLEN-1:0]  exu2ialu_main_op2_o,
   output logic             exu2ialu_rvm_cmd_vd_o,
   input  logic [XLEN-1:0]  ialu2exu_main_res_i,
   input  logic             ialu2exu_cmp_res_i,
   input  logic             ialu2exu_rvm_res_rdy_i,
   output logic             rsp_vld_o,
   input  logic             rsp_rdy_i,
   output logic [XLEN-1:0]  rsp_res_o,
   output logic             rsp_cmp_o,
   output logic [TAG_W-1:0] rsp_tag_o,
   output logic             rsp_err_o
);
   localparam int               CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [CMD_W-1:0] CMD_NONE = CMD_W'(SCR1_IALU_CMD_NONE);

   ialu_req_state_e  state;
   logic [CMD_W-1:0] cmd_q;
   logic [XLEN-1:0]  op1_q, op2_q, res_q;
   logic [TAG_W-1:0] tag_q;
   logic             cmp_q, err_q, rvm, busy;
   logic [CNT_W-1:0] cnt;

   assign rvm = ialu_cmd_is_rvm(SCR1_IALU_CMD_WIDTH_E'(cmd_q));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cmd_q <= CMD_NONE;
         op1_q <= '0;
         op2_q <= '0;
         tag_q <= '0;
         res_q <= '0;
         cmp_q <= 1'b0;
         err_q <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: if (req_vld_i) begin
               state <= ST_ISSUE;
               cmd_q <= req_cmd_i;
               op1_q <= req_op1_i;
               op2_q <= req_op2_i;
               tag_q <= req_tag_i;
            end
            ST_ISSUE: begin
               cnt <= '0;
               if (!rvm || ialu2exu_rvm_res_rdy_i) begin
                  state <= ST_RESP;
                  res_q <= ialu2exu_main_res_i;
                  cmp_q <= ialu2exu_cmp_res_i;
                  err_q <= 1'b0;
               end else begin
                  state <= ST_RVM_WAIT;
               end
            end
            ST_RVM_WAIT: begin
               cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
               // a ready result takes priority over an expiring timeout
               if (ialu2exu_rvm_res_rdy_i) begin
                  state <= ST_RESP;
                  res_q <= ialu2exu_main_res_i;
                  cmp_q <= ialu2exu_cmp_res_i;
                  err_q <= 1'b0;
               end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                  state <= ST_RESP;
                  res_q <= '0;
                  cmp_q <= 1'b0;
                  err_q <= 1'b1;
               end
            end
            ST_RESP: if (rsp_rdy_i) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy                  = state == ST_ISSUE || state == ST_RVM_WAIT;
      req_rdy_o             = state == ST_IDLE;
      exu2ialu_cmd_o        = busy ? cmd_q : CMD_NONE;
      exu2ialu_main_op1_o   = op1_q;
      exu2ialu_main_op2_o   = op2_q;
      exu2ialu_rvm_cmd_vd_o = busy && rvm;
      rsp_vld_o             = state == ST_RESP;
      rsp_res_o             = res_q;
      rsp_cmp_o             = cmp_q;
      rsp_tag_o             = tag_q;
      rsp_err_o             = err_q;
   end
endmodule

// File: tb/tb_ialu_exu_req_ctrl.sv
// tb_ialu_exu_req_ctrl: directed and random requests against an arithmetic IALU model and expected-latency reference.
module tb_ialu_exu_req_ctrl;
   import ialu_req_pkg::*;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_vld_i = 1'b0, req_rdy_o;
   logic [4:0]  req_cmd_i = '0;
   logic [31:0] req_op1_i = '0, req_op2_i = '0;
   logic [3:0]  req_tag_i = '0;
   logic [4:0]  exu2ialu_cmd_o;
   logic [31:0] exu2ialu_main_op1_o, exu2ialu_main_op2_o;
   logic        exu2ialu_rvm_cmd_vd_o;
   logic [31:0] ialu2exu_main_res_i;
   logic        ialu2exu_cmp_res_i, ialu2exu_rvm_res_rdy_i;
   logic        rsp_vld_o, rsp_rdy_i = 1'b0;
   logic [31:0] rsp_res_o;
   logic        rsp_cmp_o, rsp_err_o;
   logic [3:0]  rsp_tag_o;

   int          checks = 0, passed = 0;
   int          rdy_delay = 1;
   logic        rdy_junk = 1'b0;
   logic [7:0]  vd_cnt;

   always #5 clk = ~clk;

   ialu_exu_req_ctrl #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_cmd_i(req_cmd_i),
      .req_op1_i(req_op1_i), .req_op2_i(req_op2_i), .req_tag_i(req_tag_i),
      .exu2ialu_cmd_o(exu2ialu_cmd_o), .exu2ialu_main_op1_o(exu2ialu_main_op1_o),
      .exu2ialu_main_op2_o(exu2ialu_main_op2_o), .exu2ialu_rvm_cmd_vd_o(exu2ialu_rvm_cmd_vd_o),
      .ialu2exu_main_res_i(ialu2exu_main_res_i), .ialu2exu_cmp_res_i(ialu2exu_cmp_res_i),
      .ialu2exu_rvm_res_rdy_i(ialu2exu_rvm_res_rdy_i),
      .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i), .rsp_res_o(rsp_res_o),
      .rsp_cmp_o(rsp_cmp_o), .rsp_tag_o(rsp_tag_o), .rsp_err_o(rsp_err_o)
   );

   // arithmetic view of the IALU: returns {cmp, result}
   function automatic logic [32:0] alu(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ub;
      logic [63:0] p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ub = {32'b0, b};
      case (c)
         5'd1:  return {1'b0, a & b};
         5'd2:  return {1'b0, a | b};
         5'd3:  return {1'b0, a ^ b};
         5'd4:  return {1'b0, a + b};
         5'd5:  return {1'b0, a - b};
         5'd6:  return {$signed(a) < $signed(b), a - b};
         5'd7:  return {a < b, a - b};
         5'd8:  return {a == b, a - b};
         5'd9:  return {a != b, a - b};
         5'd10: return {$signed(a) >= $signed(b), a - b};
         5'd11: return {a >= b, a - b};
         5'd12: return {1'b0, a << b[4:0]};
         5'd13: return {1'b0, a >> b[4:0]};
         5'd14: return {1'b0, 32'($signed(a) >>> b[4:0])};
         5'd15: begin p = 64'(sa * sb); return {1'b0, p[31:0]}; end
         5'd16: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p[63:32]}; end
         5'd17: begin p = 64'(sa * ub); return {1'b0, p[63:32]}; end
         5'd18: begin p = 64'(sa * sb); return {1'b0, p[63:32]}; end
         5'd19: return {1'b0, (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == '1) ? a : 32'($signed(a) / $signed(b))};
         5'd20: return {1'b0, (b == 0) ? 32'hFFFF_FFFF : a / b};
         5'd21: return {1'b0, (b == 0) ? a : (a == 32'h8000_0000 && b == '1) ? 32'h0 : 32'($signed(a) % $signed(b))};
         5'd22: return {1'b0, (b == 0) ? a : a % b};
         default: return 33'h0;
      endcase
   endfunction

   // MUL/DIV unit raises ready in the rdy_delay-th cycle of valid (0 = never)
   always @(posedge clk or negedge rst_n)
      if (!rst_n) vd_cnt <= '0;
      else vd_cnt <= (exu2ialu_rvm_cmd_vd_o && !ialu2exu_rvm_res_rdy_i) ? vd_cnt + 8'd1 : 8'd0;

   assign ialu2exu_rvm_res_rdy_i = exu2ialu_rvm_cmd_vd_o ? (rdy_delay != 0 && 32'(vd_cnt) == rdy_delay - 1) : rdy_junk;
   assign ialu2exu_main_res_i = (exu2ialu_cmd_o != 5'd0 && (exu2ialu_cmd_o < 5'd15 || ialu2exu_rvm_res_rdy_i)) ?
                                alu(exu2ialu_cmd_o, exu2ialu_main_op1_o, exu2ialu_main_op2_o) : 32'hDEAD_BEEF;
   assign ialu2exu_cmp_res_i  = (exu2ialu_cmd_o != 5'd0) ? alu(exu2ialu_cmd_o, exu2ialu_main_op1_o, exu2ialu_main_op2_o) >> 32 != 0 : 1'b1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input int d, input int hold);
      logic [32:0] r;
      bit          is_rvm, tmo;
      int          lat, vdn, exp_lat;
      is_rvm = c >= 5'd15;
      tmo = is_rvm && d == 0;
      r = tmo ? 33'h0 : alu(c, a, b);
      exp_lat = !is_rvm ? 1 : tmo ? TMO + 1 : d;
      rdy_delay = d;
      chk("req_rdy_idle", req_rdy_o, 1);
      req_cmd_i = c; req_op1_i = a; req_op2_i = b; req_tag_i = tag; req_vld_i = 1'b1;
      tick();
      req_vld_i = 1'b0; req_op1_i = $urandom; req_op2_i = $urandom; req_cmd_i = 5'($urandom_range(1, 22));
      lat = 0;
      vdn = 0;
      do begin
         chk("issue_cmd", exu2ialu_cmd_o, c);
         chk("issue_ops", {exu2ialu_main_op1_o, exu2ialu_main_op2_o}, {a, b});
         chk("busy_req_rdy", req_rdy_o, 0);
         if (exu2ialu_rvm_cmd_vd_o) vdn++;
         tick();
         lat++;
      end while (!rsp_vld_o && lat < 40);
      chk("latency", lat, exp_lat);
      chk("vd_cycles", vdn, is_rvm ? exp_lat : 0);
      chk("resp_cmd_none", {exu2ialu_cmd_o, exu2ialu_rvm_cmd_vd_o}, 0);
      chk("resp_ops_kept", {exu2ialu_main_op1_o, exu2ialu_main_op2_o}, {a, b});
      chk("rsp_fields", {rsp_err_o, rsp_cmp_o, rsp_tag_o, rsp_res_o}, {tmo, r[32], tag, r[31:0]});
      repeat (hold) begin
         tick();
         chk("hold_rsp", {rsp_vld_o, req_rdy_o, rsp_err_o, rsp_cmp_o, rsp_tag_o, rsp_res_o},
             {1'b1, 1'b0, tmo, r[32], tag, r[31:0]});
      end
      rsp_rdy_i = 1'b1;
      tick();
      rsp_rdy_i = 1'b0;
      chk("back_idle", {rsp_vld_o, req_rdy_o}, 2'b01);
   endtask

   initial begin
      #1;
      chk("reset_outs", {req_vld_i, exu2ialu_cmd_o, exu2ialu_rvm_cmd_vd_o, rsp_vld_o, rsp_res_o, rsp_cmp_o, rsp_tag_o, rsp_err_o, exu2ialu_main_op1_o}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      run(5'd4, 32'd5, 32'd7, 4'd3, 1, 0);
      chk("add_res", rsp_res_o, 12);
      run(5'd6, 32'hFFFF_FFFF, 32'd1, 4'd1, 1, 0);
      chk("slt_cmp", rsp_cmp_o, 1);
      run(5'd7, 32'hFFFF_FFFF, 32'd1, 4'd2, 1, 0);
      chk("sltu_cmp", rsp_cmp_o, 0);
      run(5'd15, 32'd3, 32'hFFFF_FFFE, 4'd5, 4, 0);
      chk("mul_res", rsp_res_o, 32'hFFFF_FFFA);
      run(5'd19, 32'd100, 32'd7, 4'd6, 0, 0);
      chk("div_timeout", {rsp_err_o, rsp_res_o}, {1'b1, 32'd0});
      run(5'd16, 32'hFFFF_FFFF, 32'd2, 4'd7, TMO + 1, 0);
      chk("rdy_beats_timeout", {rsp_err_o, rsp_res_o}, {1'b0, 32'd1});
      run(5'd20, 32'd9, 32'd2, 4'd8, 1, 2);
      run(5'd5, 32'd1, 32'd2, 4'd9, 1, 3);
      rdy_junk = 1'b1;
      run(5'd1, 32'hF0F0_1234, 32'h0FF0_FF00, 4'd10, 1, 1);
      rdy_junk = 1'b0;
      rdy_delay = 0;
      req_cmd_i = 5'd21; req_op1_i = 32'd50; req_op2_i = 32'd3; req_tag_i = 4'd11; req_vld_i = 1'b1;
      tick();
      req_vld_i = 1'b0;
      repeat (3) tick();
      chk("mid_wait_vd", exu2ialu_rvm_cmd_vd_o, 1);
      rst_n = 1'b0;
      #1;
      chk("async_reset", {exu2ialu_cmd_o, exu2ialu_rvm_cmd_vd_o, rsp_vld_o, rsp_res_o, rsp_cmp_o, rsp_tag_o, rsp_err_o, exu2ialu_main_op1_o}, 0);
      tick();
      rst_n = 1'b1;
      begin
         int seen = 0;
         repeat (TMO + 4) begin
            tick();
            if (rsp_vld_o || exu2ialu_rvm_cmd_vd_o) seen++;
         end
         chk("no_rsp_after_reset", seen, 0);
      end
      run(5'd4, 32'h7FFF_FFFF, 32'd1, 4'd12, 1, 0);
      chk("add_after_reset", rsp_res_o, 32'h8000_0000);
      for (int i = 0; i < 40; i++) begin
         rdy_junk = 1'($urandom);
         run(5'($urandom_range(1, 22)), $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
             4'($urandom), $urandom_range(0, TMO + 1), $urandom_range(0, 2));
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
